// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//   Multi-cycle restoring divider that follows the N-bit multiplier in the
//   MulDiv datapath. It divides a 2N-bit dividend by an N-bit divisor and
//   produces one quotient bit per clock, so a division takes 2N cycles.
//   Dividing by zero finishes at once with an all-ones quotient and a flag.
//
// Handshake: START is sampled on the rising edge. It is accepted whenever the
//   divider is not BUSY, which includes the DONE cycle (back-to-back). While
//   BUSY is high, START is ignored. DONE is a one-cycle pulse. The results stay
//   valid from the DONE cycle until the next operation writes new results.
//
// Ports:
//   CLK          system clock, rising edge
//   N_RESET      asynchronous active-low reset
//   START        operation request
//   DIVIDEND     2N-bit unsigned dividend, captured on an accepted START
//   DIVISOR      N-bit unsigned divisor, captured on an accepted START
//   BUSY         high while the division steps run
//   DONE         one-cycle pulse when the results are valid
//   QUOTIENT     2N-bit quotient, held until new results are written
//   REMAINDER    N-bit remainder, held until new results are written
//   DIV_BY_ZERO  set with DONE when the captured divisor was zero
//   DBG_STATE    current FSM state (IDLE=0, RUN=1, FIN=2) for checkers
// -----------------------------------------------------------------------------
module seq_divider #(
   parameter int N = 4
) (
   input  logic           CLK,
   input  logic           N_RESET,
   input  logic           START,
   input  logic [2*N-1:0] DIVIDEND,
   input  logic [N-1:0]   DIVISOR,
   output logic           BUSY,
   output logic           DONE,
   output logic [2*N-1:0] QUOTIENT,
   output logic [N-1:0]   REMAINDER,
   output logic           DIV_BY_ZERO,
   output logic [1:0]     DBG_STATE
);

   localparam int CW = $clog2(2*N+1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [2*N-1:0] dvd_q;    // dividend; the top bit is shifted out on each step
   logic [N-1:0]   dsr_q;    // divisor
   logic [N-1:0]   prem_q;   // partial remainder, always below the divisor
   logic [2*N-1:0] quo_q;    // quotient being built
   logic [CW-1:0]  cnt_q;    // number of steps left

   logic [N:0]     shifted;
   logic           fits;
   logic [N-1:0]   prem_next;
   logic [2*N-1:0] quo_next;
   logic           last_step;

   // One restoring step. The stored remainder stays below the divisor, so
   // N bits are enough to hold it. After the shift the value can reach 2*dsr-1,
   // which needs one more bit, so the compare is done N+1 bits wide.
   always_comb begin
      shifted   = {prem_q, dvd_q[2*N-1]};
      fits      = (shifted >= {1'b0, dsr_q});
      prem_next = fits ? N'(shifted - {1'b0, dsr_q}) : shifted[N-1:0];
      quo_next  = {quo_q[2*N-2:0], fits};
      last_step = (cnt_q == CW'(1));
   end

   // FSM state register
   always_ff @(posedge CLK or negedge N_RESET) begin
      if (!N_RESET) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next state and status outputs
   always_comb begin
      state_d   = state_q;
      BUSY      = 1'b0;
      DONE      = 1'b0;
      DBG_STATE = state_q;
      case (state_q)
         IDLE, FIN: begin
            DONE = (state_q == FIN);
            if (START) state_d = (DIVISOR == '0) ? FIN : RUN;
            else       state_d = IDLE;
         end
         RUN: begin
            BUSY = 1'b1;
            if (last_step) state_d = FIN;
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath and result registers
   always_ff @(posedge CLK or negedge N_RESET) begin
      if (!N_RESET) begin
         dvd_q       <= '0;
         dsr_q       <= '0;
         prem_q      <= '0;
         quo_q       <= '0;
         cnt_q       <= '0;
         QUOTIENT    <= '0;
         REMAINDER   <= '0;
         DIV_BY_ZERO <= 1'b0;
      end else begin
         case (state_q)
            IDLE, FIN: begin
               if (START) begin
                  dvd_q  <= DIVIDEND;
                  dsr_q  <= DIVISOR;
                  prem_q <= '0;
                  quo_q  <= '0;
                  if (DIVISOR == '0) begin
                     // A zero divisor skips RUN, so the results are written now.
                     cnt_q       <= '0;
                     QUOTIENT    <= '1;
                     REMAINDER   <= '0;
                     DIV_BY_ZERO <= 1'b1;
                  end else begin
                     cnt_q       <= CW'(2*N);
                     DIV_BY_ZERO <= 1'b0;
                  end
               end
            end
            RUN: begin
               dvd_q  <= dvd_q << 1;
               prem_q <= prem_next;
               quo_q  <= quo_next;
               cnt_q  <= cnt_q - CW'(1);
               if (last_step) begin
                  QUOTIENT  <= quo_next;
                  REMAINDER <= prem_next;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
